point_ram_server: RTL and testbench

Point-memory responder for the k-means accelerator: the RAM-side counterpart of the controller's point-read interface. A host streams points in, and the block stores them in two 50-bit banks. It then publishes `first_ram_addr`/`last_ram_addr`, pulses `go`, and serves the controller's address-driven reads with one-cycle latency until the controller releases it.

---
 rtl/k_means_pkg.sv | 26 ++
 rtl/dual_bank_ram.sv | 46 ++++
 rtl/point_ram_server.sv | 157 +++++++++++++++
 tb/tb_point_ram_server.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/k_means_pkg.sv
// k_means_pkg: shared constants and types for the k-means point memory.
//   POINT_ADDR_W : point address width (512-point capacity)
//   DATA_W       : point width, 7 coordinates x 13 bits
//   RAM_WORD_LEN : width of one RAM bank word
//   ERR_*        : bit positions inside the sticky err vector
//   ram_srv_state_t : point_ram_server FSM states
package k_means_pkg;

    localparam int POINT_ADDR_W = 9;
    localparam int DATA_W       = 91;
    localparam int RAM_WORD_LEN = 50;
    localparam int POINT_CNT    = 1 << POINT_ADDR_W;

    localparam int ERR_W        = 3;
    localparam int ERR_OVERFLOW = 2;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_WRITE    = 0;

    typedef enum logic [1:0] {
        SRV_IDLE,
        SRV_LOAD,
        SRV_ARMED,
        SRV_SERVE
    } ram_srv_state_t;

endpackage

// File: rtl/dual_bank_ram.sv
// dual_bank_ram: two 512 x 50-bit synchronous-read banks sharing one address.
//   clk, rst  : clock, synchronous active-high reset (read register only)
//   addr_i    : common bank address
//   we_i      : write enable, stores wdata_i at addr_i
//   wdata_i   : 91-bit point; bank0 = [49:0], bank1 = zero-padded [90:50]
//   rd_en_i   : load the read register from addr_i
//   rdata_o   : registered read data, holds its value when rd_en_i is low
module dual_bank_ram
    import k_means_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [POINT_ADDR_W-1:0] addr_i,
    input  logic                    we_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    rd_en_i,
    output logic [DATA_W-1:0]       rdata_o
);
    localparam int HI_W = DATA_W - RAM_WORD_LEN;

    logic [RAM_WORD_LEN-1:0] bank0_q [POINT_CNT];
    logic [RAM_WORD_LEN-1:0] bank1_q [POINT_CNT];
    logic [DATA_W-1:0]       rdata_q;
    logic [RAM_WORD_LEN-1:0] hi_word;

    assign hi_word = {{(RAM_WORD_LEN-HI_W){1'b0}}, wdata_i[DATA_W-1:RAM_WORD_LEN]};

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            bank0_q[addr_i] <= wdata_i[RAM_WORD_LEN-1:0];
            bank1_q[addr_i] <= hi_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= {bank1_q[addr_i][HI_W-1:0], bank0_q[addr_i]};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/point_ram_server.sv
// point_ram_server: stores a streamed point set into dual_bank_ram, publishes
// its address range, pulses go, then serves address-driven reads (latency 1)
// until release_mem.
//   load_*            : host load stream (valid/ready, last, base address)
//   first/last_ram_addr, go : published point set
//   ram_addr, wr_en_n, output_en_n, chip_select_n : read port (all 1 = read)
//   release_mem       : return to IDLE (SERVE only)
//   point_data/valid  : read response
//   err               : sticky {overflow, range, write_attempt}
//
// state     | meaning
// SRV_IDLE  | waiting for the first word of a point set
// SRV_LOAD  | accepting consecutive words at wr_ptr+1
// SRV_ARMED | set complete, go high for this cycle
// SRV_SERVE | answering reads until release_mem
module point_ram_server
    import k_means_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [POINT_ADDR_W-1:0] load_base,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    load_last,
    output logic [POINT_ADDR_W-1:0] first_ram_addr,
    output logic [POINT_ADDR_W-1:0] last_ram_addr,
    output logic                    go,
    input  logic [POINT_ADDR_W-1:0] ram_addr,
    input  logic                    wr_en_n,
    input  logic                    output_en_n,
    input  logic                    chip_select_n,
    input  logic                    release_mem,
    output logic [DATA_W-1:0]       point_data,
    output logic                    point_valid,
    output logic [ERR_W-1:0]        err
);
    ram_srv_state_t          state_q, state_d;
    logic [POINT_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [POINT_ADDR_W-1:0] first_q, first_d;
    logic [POINT_ADDR_W-1:0] last_q, last_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic                    valid_q, valid_d;

    logic                    accept, rd_req, full, in_range;
    logic                    mem_we, mem_rd;
    logic [POINT_ADDR_W-1:0] mem_addr, next_ptr, offset, span;

    assign load_ready = (state_q == SRV_IDLE) || (state_q == SRV_LOAD);
    assign go         = (state_q == SRV_ARMED);
    assign accept     = load_valid & load_ready;
    assign rd_req     = wr_en_n & output_en_n & chip_select_n;
    assign next_ptr   = wr_ptr_q + 1'b1;
    // Next slot is the one just below the first point: memory is full.
    assign full       = (next_ptr == first_q - 1'b1);
    // Modular distance from first handles a range that wraps past 511.
    assign offset     = ram_addr - first_q;
    assign span       = last_q - first_q;
    assign in_range   = (offset <= span);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SRV_IDLE;
            wr_ptr_q <= '0;
            first_q  <= '0;
            last_q   <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            first_q  <= first_d;
            last_q   <= last_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        first_d  = first_q;
        last_d   = last_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        mem_we   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = ram_addr;

        unique case (state_q)
            SRV_IDLE: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    mem_addr = load_base;
                    wr_ptr_d = load_base;
                    first_d  = load_base;
                    err_d    = '0;
                    if (load_last) begin
                        last_d  = load_base;
                        state_d = SRV_ARMED;
                    end else begin
                        state_d = SRV_LOAD;
                    end
                end
            end
            SRV_LOAD: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    mem_addr = next_ptr;
                    wr_ptr_d = next_ptr;
                    if (load_last || full) begin
                        last_d  = next_ptr;
                        state_d = SRV_ARMED;
                        if (full && !load_last) begin
                            err_d[ERR_OVERFLOW] = 1'b1;
                        end
                    end
                end
            end
            SRV_ARMED: begin
                state_d = SRV_SERVE;
            end
            SRV_SERVE: begin
                if (rd_req) begin
                    mem_rd  = 1'b1;
                    valid_d = 1'b1;
                    if (!in_range) begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                end
                if (!wr_en_n) begin
                    err_d[ERR_WRITE] = 1'b1;
                end
                if (release_mem) begin
                    state_d = SRV_IDLE;
                end
            end
            default: state_d = SRV_IDLE;
        endcase
    end

    dual_bank_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (mem_addr),
        .we_i    (mem_we),
        .wdata_i (load_data),
        .rd_en_i (mem_rd),
        .rdata_o (point_data)
    );

    assign first_ram_addr = first_q;
    assign last_ram_addr  = last_q;
    assign err            = err_q;
    assign point_valid    = valid_q;

endmodule

// File: tb/tb_point_ram_server.sv
module tb_point_ram_server;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  load_base;
    logic        load_valid;
    logic        load_ready;
    logic [90:0] load_data;
    logic        load_last;
    logic [8:0]  first_ram_addr;
    logic [8:0]  last_ram_addr;
    logic        go;
    logic [8:0]  ram_addr;
    logic        wr_en_n;
    logic        output_en_n;
    logic        chip_select_n;
    logic        release_mem;
    logic [90:0] point_data;
    logic        point_valid;
    logic [2:0]  err;

    int checks   = 0;
    int failures = 0;

    // Reference model: memory image, published range, sticky errors, phase.
    logic [90:0] model_mem [512];
    bit          written   [512];
    logic [8:0]  exp_first, exp_last;
    logic [2:0]  exp_err;
    logic [90:0] exp_data;
    bit          serving;

    always #5 clk = ~clk;

    point_ram_server dut (
        .clk            (clk),
        .rst            (rst),
        .load_base      (load_base),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_last      (load_last),
        .first_ram_addr (first_ram_addr),
        .last_ram_addr  (last_ram_addr),
        .go             (go),
        .ram_addr       (ram_addr),
        .wr_en_n        (wr_en_n),
        .output_en_n    (output_en_n),
        .chip_select_n  (chip_select_n),
        .release_mem    (release_mem),
        .point_data     (point_data),
        .point_valid    (point_valid),
        .err            (err)
    );

    task automatic chk(input string tag, input logic [90:0] got, input logic [90:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_in_set(input int a);
        int off;
        int len;
        off = (a - int'(exp_first) + 512) % 512;
        len = (int'(exp_last) - int'(exp_first) + 512) % 512;
        return off <= len;
    endfunction

    task automatic idle_inputs();
        load_valid    = 1'b0;
        load_last     = 1'b0;
        wr_en_n       = 1'b1;
        output_en_n   = 1'b0;
        chip_select_n = 1'b1;
        release_mem   = 1'b0;
    endtask

    task automatic do_reset(input bit with_read);
        rst = 1'b1;
        if (with_read) begin
            output_en_n = 1'b1;
            ram_addr    = exp_first;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        serving   = 0;
        exp_first = '0;
        exp_last  = '0;
        exp_err   = '0;
        exp_data  = '0;
        chk("rst_valid", point_valid, 0);
        chk("rst_data", point_data, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_go", go, 0);
        chk("rst_first", first_ram_addr, 0);
        chk("rst_last", last_ram_addr, 0);
        chk("rst_err", err, 0);
    endtask

    // Streams n points from base; the set completes on load_last or when
    // the 512th word fills the memory.
    task automatic load_points(input logic [8:0] base, input int n, input bit use_last);
        logic [95:0] r;
        logic [8:0]  a;
        bit          arm;
        arm = use_last || (n == 512);
        load_base = base;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
                chk("gap_ready", load_ready, 1);
            end
            r = {$urandom, $urandom, $urandom};
            a = base + 9'(i);
            load_valid   = 1'b1;
            load_data    = r[90:0];
            load_last    = use_last && (i == n - 1);
            model_mem[a] = r[90:0];
            written[a]   = 1;
            @(posedge clk); #1;
            if (i == 0) begin
                exp_first = base;
                exp_err   = '0;
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
            load_base  = 9'($urandom_range(0, 511));
            if (i < n - 1) begin
                chk("load_go", go, 0);
                chk("load_ready", load_ready, 1);
            end
        end
        if (arm) begin
            exp_last = base + 9'(n - 1);
            if (!use_last) exp_err[2] = 1'b1;
            chk("armed_go", go, 1);
            chk("armed_ready", load_ready, 0);
            chk("first_addr", first_ram_addr, exp_first);
            chk("last_addr", last_ram_addr, exp_last);
            chk("armed_err", err, exp_err);
            @(posedge clk); #1;
            chk("go_once", go, 0);
            chk("serve_ready", load_ready, 0);
            serving = 1;
        end
    endtask

    task automatic read_cycle(input logic [8:0] a, input logic we_n, input logic oe_n,
                              input logic cs_n, input logic rel);
        bit req;
        ram_addr      = a;
        wr_en_n       = we_n;
        output_en_n   = oe_n;
        chip_select_n = cs_n;
        release_mem   = rel;
        @(posedge clk); #1;
        idle_inputs();
        req = serving && we_n && oe_n && cs_n;
        if (req) begin
            exp_data = model_mem[a];
            if (!addr_in_set(int'(a))) exp_err[1] = 1'b1;
        end
        if (serving && !we_n) exp_err[0] = 1'b1;
        if (serving && rel) serving = 0;
        chk("rd_valid", point_valid, req);
        chk("rd_data", point_data, exp_data);
        chk("rd_err", err, exp_err);
        chk("rd_ready", load_ready, !serving);
    endtask

    task automatic random_reads(input int n);
        logic [8:0] a;
        int         mode;
        int         len;
        for (int i = 0; i < n; i++) begin
            len = (int'(exp_last) - int'(exp_first) + 512) % 512;
            a = 9'($urandom_range(0, 511));
            if (!written[a] || $urandom_range(0, 3) != 0)
                a = exp_first + 9'($urandom_range(0, len));
            mode = $urandom_range(0, 7);
            case (mode)
                0: read_cycle(a, 1'b1, 1'b1, 1'b0, 1'b0);
                1: read_cycle(a, 1'b1, 1'b0, 1'b1, 1'b0);
                2: read_cycle(a, 1'b0, 1'b1, 1'b1, 1'b0);
                default: read_cycle(a, 1'b1, 1'b1, 1'b1, 1'b0);
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            model_mem[i] = '0;
            written[i]   = 0;
        end
        rst       = 1'b1;
        load_base = '0;
        load_data = '0;
        ram_addr  = '0;
        idle_inputs();
        @(posedge clk); #1;
        do_reset(0);

        // Reads outside SERVE are ignored.
        read_cycle(9'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Four points at base 10, read back to back.
        load_points(9'd10, 4, 1);
        for (int i = 10; i <= 13; i++) read_cycle(9'(i), 1'b1, 1'b1, 1'b1, 1'b0);
        random_reads(40);
        read_cycle(9'd11, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("idle_go", go, 0);

        // Wrapping set 510,511,0 plus error flags.
        load_points(9'd510, 3, 1);
        chk("wrap_err_clear", err, 0);
        read_cycle(9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        read_cycle(9'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("range_err", err[1], 1);
        read_cycle(9'd510, 1'b1, 1'b1, 1'b0, 1'b0);
        read_cycle(9'd511, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("write_err", err[0], 1);
        random_reads(30);
        read_cycle(9'd511, 1'b1, 1'b1, 1'b1, 1'b1);

        // Full memory without load_last.
        load_points(9'($urandom_range(0, 511)), 512, 0);
        chk("full_last", last_ram_addr, exp_first - 9'd1);
        random_reads(30);
        read_cycle(exp_first, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a load, then a fresh load.
        load_points(9'd100, 2, 0);
        do_reset(0);
        load_points(9'($urandom_range(0, 511)), $urandom_range(1, 20), 1);
        random_reads(30);

        // Reset with a read request pending in SERVE.
        do_reset(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got=%0d exp=0", 1);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
